// File: rtl/sound_scheduler_pkg.sv
// Shared types and constants for the sound scheduler and the song player.
package sound_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_e;

    // Note codes shared with the player; OFF is the rest/silence code.
    typedef enum logic [3:0] {
        NOTE_C = 4'h0,
        NOTE_D = 4'h1,
        NOTE_E = 4'h2,
        NOTE_F = 4'h3,
        NOTE_G = 4'h4,
        NOTE_A = 4'h5,
        NOTE_B = 4'h6,
        OFF    = 4'hF
    } note_e;

    localparam logic [3:0] NOTE_OFF = 4'(OFF);
    localparam int         TICK_W   = 24;

endpackage

// File: rtl/sound_scheduler_tempo_ticker.sv
// Note-step divider: counts clk cycles and strobes tick at the end of each period.
module tempo_ticker
    import sound_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              hold,
    input  logic [TICK_W-1:0] period,
    output logic              tick
);

    logic [TICK_W-1:0] count_q;
    logic [TICK_W-1:0] count_d;
    logic              wrap;

    // Terminal-count compare; clear wins over hold, hold freezes the step position
    always_comb begin
        wrap    = (count_q == (period - TICK_W'(1)));
        tick    = wrap && !clr && !hold;
        count_d = count_q + TICK_W'(1);
        if (clr) begin
            count_d = '0;
        end else if (hold) begin
            count_d = count_q;
        end else if (wrap) begin
            count_d = '0;
        end
    end

    // Step counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sound_scheduler.sv
// Playback sequencer: play/pause/stop/next control, song index, tempo tick and note mux.
module sound_scheduler
    import sound_scheduler_pkg::*;
#(
    parameter logic [23:0] TICK_DIV0 = 24'd2_500_000,
    parameter logic [23:0] TICK_DIV1 = 24'd2_000_000,
    parameter logic [23:0] TICK_DIV2 = 24'd1_666_667,
    parameter logic [23:0] TICK_DIV3 = 24'd1_250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play_edge,
    input  logic       stop_edge,
    input  logic       next_edge,
    input  logic       loop_en,
    input  logic [1:0] tempo_sel,
    input  logic       song_done,
    input  logic [3:0] player_note,
    input  logic       key_valid,
    input  logic [3:0] key_note,
    output logic       tick,
    output logic       start,
    output logic       player_run,
    output logic [1:0] song_sel,
    output logic [3:0] note_out
);

    state_e            state_q;
    state_e            state_d;
    logic [1:0]        song_sel_q;
    logic [1:0]        song_sel_d;
    logic              start_q;
    logic              start_d;
    logic [3:0]        note_q;
    logic [3:0]        note_d;
    logic [TICK_W-1:0] period_q;
    logic [TICK_W-1:0] period_d;
    logic [TICK_W-1:0] tempo_div;
    logic              tick_w;
    logic              ticker_clr;
    logic              ticker_hold;

    // State, song index, start pulse, latched period and note registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            song_sel_q <= 2'd0;
            start_q    <= 1'b0;
            note_q     <= NOTE_OFF;
            period_q   <= TICK_DIV0;
        end else begin
            state_q    <= state_d;
            song_sel_q <= song_sel_d;
            start_q    <= start_d;
            note_q     <= note_d;
            period_q   <= period_d;
        end
    end

    // Next state; events in priority order stop > play > next > song_done
    always_comb begin
        state_d    = state_q;
        song_sel_d = song_sel_q;
        start_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!stop_edge) begin
                    if (play_edge) begin
                        state_d = PLAY;
                        start_d = 1'b1;
                    end else if (next_edge) begin
                        song_sel_d = song_sel_q + 2'd1;
                    end
                end
            end
            PLAY: begin
                if (stop_edge) begin
                    state_d = IDLE;
                end else if (play_edge) begin
                    state_d = PAUSE;
                end else if (next_edge) begin
                    song_sel_d = song_sel_q + 2'd1;
                    start_d    = 1'b1;
                end else if (song_done) begin
                    if (loop_en) begin
                        start_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            PAUSE: begin
                if (stop_edge) begin
                    state_d = IDLE;
                end else if (play_edge) begin
                    state_d = PLAY;
                end else if (next_edge) begin
                    song_sel_d = song_sel_q + 2'd1;
                    start_d    = 1'b1;
                    state_d    = PLAY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and ticker controls; the counter restarts on start so tick never overlaps it
    always_comb begin
        player_run  = (state_q == PLAY);
        start       = start_q;
        tick        = tick_w;
        song_sel    = song_sel_q;
        note_out    = note_q;
        ticker_clr  = (state_q == IDLE) || start_q;
        ticker_hold = (state_q == PAUSE);
    end

    // Tempo latch (only at step boundaries) and live-key note mux
    always_comb begin
        case (tempo_sel)
            2'd0:    tempo_div = TICK_DIV0;
            2'd1:    tempo_div = TICK_DIV1;
            2'd2:    tempo_div = TICK_DIV2;
            default: tempo_div = TICK_DIV3;
        endcase
        period_d = period_q;
        if ((state_q == IDLE) || start_q || tick_w) begin
            period_d = tempo_div;
        end
        if (key_valid && (key_note != NOTE_OFF)) begin
            note_d = key_note;
        end else if (state_q == PLAY) begin
            note_d = player_note;
        end else begin
            note_d = NOTE_OFF;
        end
    end

    tempo_ticker u_ticker (
        .clk    (clk),
        .rst    (rst),
        .clr    (ticker_clr),
        .hold   (ticker_hold),
        .period (period_q),
        .tick   (tick_w)
    );

endmodule

// File: doc/sound_scheduler.md
SOUND_SCHEDULER -- requirements
Module: sound_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV0, default 24'd2_500_000, meaning the tick period in clk cycles for tempo_sel=0.
REQ-002 SHALL have parameters TICK_DIV1, TICK_DIV2 and TICK_DIV3, defaults 24'd2_000_000, 24'd1_666_667 and 24'd1_250_000, meaning the tick periods for tempo_sel=1..3.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port play_edge, input, 1 bit: one-cycle play/pause button pulse.
REQ-006 SHALL have port stop_edge, input, 1 bit: one-cycle stop button pulse.
REQ-007 SHALL have port next_edge, input, 1 bit: one-cycle next-song button pulse.
REQ-008 SHALL have port loop_en, input, 1 bit: level; restart the current song when it ends.
REQ-009 SHALL have port tempo_sel, input, 2 bits: selects TICK_DIVn.
REQ-010 SHALL have port song_done, input, 1 bit: one-cycle pulse from the player at the last note step.
REQ-011 SHALL have port player_note, input, 4 bits: note code from the player (4'hF = rest).
REQ-012 SHALL have port key_valid, input, 1 bit, and port key_note, input, 4 bits: live keypad note.
REQ-013 SHALL have port tick, output, 1 bit: one-cycle note-step strobe to the player.
REQ-014 SHALL have port start, output, 1 bit: one-cycle pulse that rewinds the player to step 0.
REQ-015 SHALL have port player_run, output, 1 bit: high while the player may advance.
REQ-016 SHALL have port song_sel, output, 2 bits: index of the active song.
REQ-017 SHALL have port note_out, output, 4 bits: registered note to the oscillator.

Function
REQ-018 SHALL implement the FSM states IDLE, PLAY and PAUSE, with player_run = (state==PLAY).
REQ-019 In the same cycle, event priority SHALL be stop_edge > play_edge > next_edge > song_done.
REQ-020 In IDLE: play_edge -> PLAY with start=1; next_edge -> song_sel+1, stay IDLE, start=0.
REQ-021 In PLAY: stop_edge -> IDLE; play_edge -> PAUSE; next_edge -> song_sel+1, start=1, stay PLAY.
REQ-022 In PLAY with song_done: if loop_en=1, stay PLAY and start=1; if loop_en=0, go to IDLE.
REQ-023 In PAUSE: stop_edge -> IDLE; play_edge -> PLAY with no start (resume); next_edge -> song_sel+1, start=1, PLAY.
REQ-024 song_sel SHALL wrap 3 -> 0 modulo 4; song_sel SHALL NOT change on stop_edge.
REQ-025 Tick counter, 24 bits: cleared in IDLE and in any cycle start=1; holds its value in PAUSE; increments in PLAY.
REQ-026 tick SHALL be 1 for one cycle when state==PLAY and count==period-1; count then wraps to 0.
REQ-027 The period SHALL be latched from tempo_sel only on wrap, on start, or while in IDLE (no mid-step tempo glitch).
REQ-028 The first tick after start SHALL occur exactly period cycles after the cycle start is asserted.
REQ-029 tick and start SHALL never be high in the same cycle.
REQ-030 note_out next value: key_note if key_valid=1 and key_note!=4'hF; else player_note if state==PLAY; else 4'hF.
REQ-031 note_out latency SHALL be 1 clk from its inputs; live key overrides PLAY and PAUSE without changing FSM state or the counter.
REQ-032 song_done SHALL be ignored outside PLAY.

Reset
REQ-033 On rst=1 (asynchronous), outputs SHALL reset to: state=IDLE, count=0, period=TICK_DIV0, song_sel=0, tick=0, start=0, player_run=0, note_out=4'hF.
REQ-034 Reset asserted mid-PLAY SHALL take effect immediately with no trailing tick or start.
REQ-035 After rst deasserts, the first clk edge SHALL evaluate normally.

Structure
REQ-036 A shared package SHALL hold the state enum (IDLE, PLAY, PAUSE), the note-code enum with OFF=4'hF shared with the player, and the constant NOTE_OFF.
REQ-037 The tempo divider SHALL be a sub-module tempo_ticker (inputs: clk, rst, clr, hold, period; output: tick).
REQ-038 The FSM, song_sel register and note mux SHALL be in the top level.

Verification (bench parameters TICK_DIVn = 4, 6, 8, 10)
REQ-039 rst, then play_edge with tempo_sel=0 -> start at cycle 1, tick pulses at +4, +8, +12; note_out follows player_note with 1-cycle delay.
REQ-040 PLAY, pause at count=2, wait 20 cycles, play_edge -> no tick while paused; next tick 2 cycles after resume; start stays 0.
REQ-041 song_sel=3, next_edge in PLAY -> song_sel=0, start=1, count=0; next tick 4 cycles later.
REQ-042 song_done with loop_en=1 -> start=1, stay PLAY; song_done with loop_en=0 -> IDLE, note_out=4'hF next cycle.
REQ-043 stop_edge and play_edge in the same cycle in PLAY -> IDLE; key_valid=1, key_note=4'h4 in IDLE -> note_out=4'h4 next cycle.
REQ-044 rst pulse mid-step in PLAY -> all outputs at reset values immediately; song_sel=0.
